// File: rtl/seq_mul_add_pkg.sv
// Shared constants for the shift-add multiply-accumulate unit.
// State encoding and default operand width.
package seq_mul_add_pkg;

  localparam int DEFAULT_WIDTH = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_add_if.sv
// Start/ready handshake and operand/result bus of seq_mul_add.
// The master requests an operation and the slave (the unit) returns P.
interface seq_mul_add_if import seq_mul_add_pkg::*; #(
  parameter int x = DEFAULT_WIDTH
);

  logic           start;
  logic [x-1:0]   Q;
  logic [x-1:0]   B;
  logic [x-1:0]   R;
  logic           busy;
  logic           ready;
  logic [2*x-1:0] P;

  modport master (
    output start, Q, B, R,
    input  busy, ready, P
  );

  modport slave (
    input  start, Q, B, R,
    output busy, ready, P
  );

endinterface

// File: rtl/seq_mul_add_ctrl.sv
// Control path of seq_mul_add: FSM plus iteration counter.
// Finishes at count==x-1, or earlier when last_iter is raised by the datapath.
//
//   state  | meaning
//   -------+----------------------------------------------
//   S_IDLE | no result yet, waiting for start
//   S_RUN  | one shift-add iteration per clock
//   S_DONE | result valid on P, start launches a new op
module seq_mul_add_ctrl import seq_mul_add_pkg::*; #(
  parameter int x = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic last_iter,
  output logic load,
  output logic busy,
  output logic ready
);

  localparam int CNT_W = (x > 1) ? $clog2(x) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(x - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  // busy is high exactly in S_RUN, so this is the accept condition in IDLE/DONE
  assign load = start && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_RUN;
            count <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        S_RUN: begin
          count <= count + 1'b1;
          if (count == LAST || last_iter) begin
            state <= S_DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_mul_add.sv
// Sequential shift-add multiply-accumulate: P = Q*B + R over x iterations.
// Optional SEQ_MUL_ADD_EARLY_TERM_EN stops as soon as the multiplier is exhausted.
module seq_mul_add import seq_mul_add_pkg::*; #(
  parameter int x = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  seq_mul_add_if.slave bus
);

  logic [2*x-1:0] acc;
  logic [2*x-1:0] mcand;
  logic [x-1:0]   mplier;
  logic           load;
  logic           busy;
  logic           ready;
  logic           last_iter;

`ifdef SEQ_MUL_ADD_EARLY_TERM_EN
  // Post-shift multiplier is zero: no further additions can change acc.
  assign last_iter = (mplier[x-1:1] == '0);
`else
  assign last_iter = 1'b0;
`endif

  seq_mul_add_ctrl #(.x(x)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .last_iter (last_iter),
    .load      (load),
    .busy      (busy),
    .ready     (ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= {{x{1'b0}}, bus.R};
      mcand  <= {{x{1'b0}}, bus.B};
      mplier <= bus.Q;
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign bus.busy  = busy;
  assign bus.ready = ready;
  assign bus.P     = acc;

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add: directed plan cases plus random ops
// compared against P = Q*B + R and the expected completion latency.
module tb_seq_mul_add;

  localparam int X = 24;
  localparam int BUDGET = 200;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_mul_add_if #(.x(X)) bus ();

  seq_mul_add #(.x(X)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*X-1:0] ref_p(input logic [X-1:0] q, input logic [X-1:0] b,
                                           input logic [X-1:0] r);
    logic [2*X-1:0] p;
    p = (2*X)'(q) * (2*X)'(b) + (2*X)'(r);
    return p;
  endfunction

  // Iteration edges from accept to completion.
  function automatic int exp_lat(input logic [X-1:0] q);
    int n;
    n = X;
`ifdef SEQ_MUL_ADD_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < X; i++) if (q[i]) n = i + 1;
`else
    if (q === 'x) n = X;
`endif
    return n;
  endfunction

  // Called at a negedge. Launches one op, optionally pokes start with junk
  // operands after edge inject_at, and returns at the negedge where ready=1.
  task automatic run_op(input logic [X-1:0] q, input logic [X-1:0] b, input logic [X-1:0] r,
                        input int inject_at, output logic [2*X-1:0] p, output int lat,
                        output bit busy_ok);
    bus.start = 1'b1;
    bus.Q = q;
    bus.B = b;
    bus.R = r;
    @(negedge clk);
    bus.start = 1'b0;
    bus.Q = X'($urandom);
    bus.B = X'($urandom);
    bus.R = X'($urandom);
    busy_ok = (bus.busy === 1'b1 && bus.ready === 1'b0);
    lat = 0;
    while (bus.ready !== 1'b1 && lat < BUDGET) begin
      if (lat == inject_at) begin
        bus.start = 1'b1;
        bus.Q = X'($urandom);
        bus.B = X'($urandom);
        bus.R = X'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.ready !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    p = bus.P;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.Q = 24'd3;
    bus.B = 24'd5;
    bus.R = 24'd7;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.P !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ready=%b P=%h, required 0 0 0",
               bus.busy, bus.ready, bus.P);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b ready=%b, required 0 0", bus.busy, bus.ready);
    end
  endtask

  task automatic test_directed();
    logic [X-1:0] tq[4];
    logic [X-1:0] tb_[4];
    logic [X-1:0] tr[4];
    logic [2*X-1:0] want[4];
    logic [2*X-1:0] p;
    int lat;
    bit busy_ok;
    tq[0] = 24'd3;       tb_[0] = 24'd5;       tr[0] = 24'd7;       want[0] = 48'd22;
    tq[1] = 24'hFFFFFF;  tb_[1] = 24'hFFFFFF;  tr[1] = 24'hFFFFFF;  want[1] = 48'hFFFFFF000000;
    tq[2] = 24'd142;     tb_[2] = 24'd7;       tr[2] = 24'd6;       want[2] = 48'd1000;
    tq[3] = 24'd0;       tb_[3] = 24'd123;     tr[3] = 24'd9;       want[3] = 48'd9;
    for (int i = 0; i < 4; i++) begin
      run_op(tq[i], tb_[i], tr[i], -1, p, lat, busy_ok);
      checks++;
      if (p !== want[i]) begin
        errors++;
        $display("FAIL directed_p[%0d]: got %h, required %h", i, p, want[i]);
      end
      checks++;
      if (lat != exp_lat(tq[i]) || !busy_ok) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges busy_ok=%0b, required %0d edges",
                 i, lat, busy_ok, exp_lat(tq[i]));
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.P !== want[i] || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL done_hold[%0d]: P=%h ready=%b busy=%b, required %h 1 0",
                 i, bus.P, bus.ready, bus.busy, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [X-1:0] q, b, r;
    logic [2*X-1:0] p;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: q = X'($urandom_range(0, 3));
        1: q = X'($urandom) >> $urandom_range(0, X - 1);
        default: q = X'($urandom);
      endcase
      b = X'($urandom);
      r = X'($urandom);
      run_op(q, b, r, -1, p, lat, busy_ok);
      checks++;
      if (p !== ref_p(q, b, r) || lat != exp_lat(q) || !busy_ok) begin
        errors++;
        $display("FAIL random[%0d] Q=%h B=%h R=%h: P=%h lat=%0d busy_ok=%0b, required P=%h lat=%0d",
                 i, q, b, r, p, lat, busy_ok, ref_p(q, b, r), exp_lat(q));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2*X-1:0] p;
    int lat;
    bit busy_ok;
    bus.start = 1'b1;
    bus.Q = X'($urandom) | 24'h800000;
    bus.B = X'($urandom);
    bus.R = X'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.P !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ready=%b P=%h, required 0 0 0",
               bus.busy, bus.ready, bus.P);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b ready=%b, required 0 0", bus.busy, bus.ready);
    end
    run_op(24'd2, 24'd2, 24'd0, -1, p, lat, busy_ok);
    checks++;
    if (p !== 48'd4 || lat != exp_lat(24'd2) || !busy_ok) begin
      errors++;
      $display("FAIL reset_mid_restart: P=%h lat=%0d, required P=4 lat=%0d", p, lat, exp_lat(24'd2));
    end
  endtask

  task automatic test_start_ignored();
    logic [X-1:0] q, b, r;
    logic [2*X-1:0] p;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 4; i++) begin
      q = X'($urandom) | 24'h800000;
      b = X'($urandom);
      r = X'($urandom);
      run_op(q, b, r, 4 + i, p, lat, busy_ok);
      checks++;
      if (p !== ref_p(q, b, r) || lat != exp_lat(q) || !busy_ok) begin
        errors++;
        $display("FAIL start_ignored[%0d]: P=%h lat=%0d, required P=%h lat=%0d",
                 i, p, lat, ref_p(q, b, r), exp_lat(q));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [X-1:0] q, b, r;
    logic [2*X-1:0] p;
    int lat;
    bit busy_ok;
    // Each op is launched at the same negedge where the previous one showed ready.
    for (int i = 0; i < 4; i++) begin
      q = X'($urandom);
      b = X'($urandom);
      r = X'($urandom);
      run_op(q, b, r, -1, p, lat, busy_ok);
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("FAIL b2b_ready_drop[%0d]: ready did not drop or busy not raised after accept", i);
      end
      checks++;
      if (p !== ref_p(q, b, r) || lat != exp_lat(q)) begin
        errors++;
        $display("FAIL b2b_result[%0d]: P=%h lat=%0d, required P=%h lat=%0d",
                 i, p, lat, ref_p(q, b, r), exp_lat(q));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.Q = '0;
    bus.B = '0;
    bus.R = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
